// File: rtl/decode_stage_pkg.sv
// Shared types and constants for the decode stage.
// Field layout: [8:6] opcode, [5:3] Ra, [2:0] Rb.
package decode_stage_pkg;

    localparam int IW     = 9;
    localparam int RW     = 3;
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        LSH = 3'd1,
        RSH = 3'd2,
        XOR = 3'd3,
        AND = 3'd4,
        SUB = 3'd5,
        CLR = 3'd6,
        ILL = 3'd7
    } op_mne;

    typedef struct packed {
        op_mne      op;
        logic [2:0] ra;
        logic [2:0] rb;
    } dec_t;

    localparam int   DEC_W   = $bits(dec_t);
    localparam dec_t DEC_RST = '{op: CLR, ra: 3'd0, rb: 3'd0};

    function automatic dec_t decode(input logic [IW-1:0] inst);
        dec_t d;
        d.op = op_mne'(inst[OP_MSB:OP_LSB]);
        d.ra = inst[2*RW-1:RW];
        d.rb = inst[RW-1:0];
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and ALU-side valid/ready bundles for the decode stage.
// The producer of each bundle uses the master modport.
interface decode_in_if;
    import decode_stage_pkg::*;

    logic [IW-1:0] InstIn;
    logic          InValid;
    logic          InReady;

    modport master (output InstIn, output InValid, input InReady);
    modport slave  (input InstIn, input InValid, output InReady);
endinterface

interface decode_out_if;
    import decode_stage_pkg::*;

    logic          OutValid;
    logic          OutReady;
    op_mne         OutOp;
    logic [RW-1:0] OutRa;
    logic [RW-1:0] OutRb;

    modport master (
        output OutValid, output OutOp, output OutRa, output OutRb,
        input OutReady
    );
    modport slave (
        input OutValid, input OutOp, input OutRa, input OutRb,
        output OutReady
    );
endinterface

// File: rtl/decode_stage_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output,
// skid entry absorbs one beat so in_ready_o can be registered.
module skid_buf #(
    parameter int           W       = 9,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         m_v_q, m_v_d;
    logic         s_v_q, s_v_d;
    logic [W-1:0] m_q, m_d;
    logic [W-1:0] s_q, s_d;
    logic         pop, acc;

    assign in_ready_o  = !s_v_q;
    assign out_valid_o = m_v_q;
    assign out_data_o  = m_q;

    assign pop = m_v_q && out_ready_i;
    assign acc = in_valid_i && !s_v_q;

    always_comb begin
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        m_d   = m_q;
        s_d   = s_q;
        if (pop && s_v_q) begin
            // skid full means in_ready_o is low, so no accept here
            m_d   = s_q;
            s_v_d = 1'b0;
        end else if (acc && (!m_v_q || pop)) begin
            m_d   = in_data_i;
            m_v_d = 1'b1;
        end else if (acc) begin
            s_d   = in_data_i;
            s_v_d = 1'b1;
        end else if (pop) begin
            m_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_v_q <= 1'b0;
            s_v_q <= 1'b0;
            m_q   <= RST_VAL;
            s_q   <= RST_VAL;
        end else begin
            m_v_q <= m_v_d;
            s_v_q <= s_v_d;
            m_q   <= m_d;
            s_q   <= s_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, illegal-opcode filter, skid buffer.
// Optional DECODE_STALL_CNT_EN adds a saturating output-stall counter.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic         Clk_i,
    input  logic         Reset_i,
    decode_in_if.slave   in_if,
    decode_out_if.master out_if,
`ifdef DECODE_STALL_CNT_EN
    output logic [15:0]  StallCnt_o,
`endif
    output logic         IllegalSeen_o
);

    dec_t dec;
    dec_t m_dec;
    logic legal;
    logic sb_in_ready;
    logic ill_acc;
    logic ill_q, ill_d;

    assign dec   = decode(in_if.InstIn);
    assign legal = (dec.op != ILL);

    assign in_if.InReady = sb_in_ready;

    // Illegal words are consumed here and never reach the buffer.
    assign ill_acc = in_if.InValid && sb_in_ready && !legal;
    assign ill_d   = ill_q || ill_acc;

    skid_buf #(
        .W       (DEC_W),
        .RST_VAL (DEC_RST)
    ) u_skid (
        .clk_i       (Clk_i),
        .rst_i       (Reset_i),
        .in_valid_i  (in_if.InValid && legal),
        .in_ready_o  (sb_in_ready),
        .in_data_i   (dec),
        .out_valid_o (out_if.OutValid),
        .out_ready_i (out_if.OutReady),
        .out_data_o  (m_dec)
    );

    assign out_if.OutOp = m_dec.op;
    assign out_if.OutRa = m_dec.ra;
    assign out_if.OutRb = m_dec.rb;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) ill_q <= 1'b0;
        else         ill_q <= ill_d;
    end

    assign IllegalSeen_o = ill_q;

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_if.OutValid && !out_if.OutReady && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) stall_q <= 16'd0;
        else         stall_q <= stall_d;
    end

    assign StallCnt_o = stall_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change and outputs are sampled on the falling edge.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk;
    logic rst;
    logic ill_seen;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks;
    int errors;

    decode_in_if  inb ();
    decode_out_if outb ();

    decode_stage dut (
        .Clk_i         (clk),
        .Reset_i       (rst),
        .in_if         (inb.slave),
        .out_if        (outb.master),
`ifdef DECODE_STALL_CNT_EN
        .StallCnt_o    (stall_cnt),
`endif
        .IllegalSeen_o (ill_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input op_mne op,
                           input logic [2:0] ra, input logic [2:0] rb);
        chk({tag, "_valid"}, 32'(outb.OutValid), 32'd1);
        chk({tag, "_op"}, 32'(outb.OutOp), 32'(op));
        chk({tag, "_ra"}, 32'(outb.OutRa), 32'(ra));
        chk({tag, "_rb"}, 32'(outb.OutRb), 32'(rb));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        inb.InstIn    = '0;
        inb.InValid   = 1'b0;
        outb.OutReady = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_outvalid", 32'(outb.OutValid), 32'd0);
        chk("rst_inready", 32'(inb.InReady), 32'd1);
        chk("rst_op", 32'(outb.OutOp), 32'(CLR));
        chk("rst_ra", 32'(outb.OutRa), 32'd0);
        chk("rst_rb", 32'(outb.OutRb), 32'd0);
        chk("rst_ill", 32'(ill_seen), 32'd0);
        rst = 1'b0;

        // 1: single ADD, one-cycle latency
        inb.InstIn    = 9'b000_001_010;
        inb.InValid   = 1'b1;
        outb.OutReady = 1'b1;
        @(negedge clk);
        chk_out("t1", ADD, 3'd1, 3'd2);
        inb.InValid = 1'b0;
        @(negedge clk);
        chk("t1_drain", 32'(outb.OutValid), 32'd0);

        // 2: backpressure fills M then S, third word held
        outb.OutReady = 1'b0;
        inb.InstIn    = 9'b001_000_101;
        inb.InValid   = 1'b1;
        @(negedge clk);
        chk("t2_rdy_a", 32'(inb.InReady), 32'd1);
        chk_out("t2_a", LSH, 3'd0, 3'd5);
        inb.InstIn = 9'b010_001_011;
        @(negedge clk);
        chk("t2_rdy_b", 32'(inb.InReady), 32'd0);
        inb.InstIn = 9'b110_010_010;
        @(negedge clk);
        chk("t2_rdy_c", 32'(inb.InReady), 32'd0);
        chk_out("t2_hold", LSH, 3'd0, 3'd5);
        outb.OutReady = 1'b1;
        @(negedge clk);
        chk_out("t2_b", RSH, 3'd1, 3'd3);
        chk("t2_rdy_d", 32'(inb.InReady), 32'd1);
        @(negedge clk);
        chk_out("t2_c", CLR, 3'd2, 3'd2);
        inb.InValid = 1'b0;
        @(negedge clk);
        chk("t2_drain", 32'(outb.OutValid), 32'd0);

        // 3: 8 back-to-back words at full rate
        inb.InValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inb.InstIn = {3'(i % 7), 3'(i), 3'(7 - i)};
            @(negedge clk);
            chk("t3_rdy", 32'(inb.InReady), 32'd1);
            chk_out("t3", op_mne'(3'(i % 7)), 3'(i), 3'(7 - i));
        end
        inb.InValid = 1'b0;
        @(negedge clk);
        chk("t3_drain", 32'(outb.OutValid), 32'd0);

        // 4: illegal word between two ADDs is dropped and flagged
        inb.InValid = 1'b1;
        inb.InstIn  = 9'b000_001_001;
        @(negedge clk);
        chk_out("t4_a", ADD, 3'd1, 3'd1);
        chk("t4_ill0", 32'(ill_seen), 32'd0);
        inb.InstIn = 9'b111_011_100;
        @(negedge clk);
        chk("t4_gap", 32'(outb.OutValid), 32'd0);
        chk("t4_ill1", 32'(ill_seen), 32'd1);
        inb.InstIn = 9'b000_010_011;
        @(negedge clk);
        chk_out("t4_b", ADD, 3'd2, 3'd3);
        inb.InValid = 1'b0;
        @(negedge clk);
        chk("t4_drain", 32'(outb.OutValid), 32'd0);
        chk("t4_ill2", 32'(ill_seen), 32'd1);

        // 5: async reset with both entries full
        outb.OutReady = 1'b0;
        inb.InValid   = 1'b1;
        inb.InstIn    = 9'b001_000_101;
        @(negedge clk);
        inb.InstIn = 9'b010_001_011;
        @(negedge clk);
        chk("t5_full", 32'(inb.InReady), 32'd0);
        inb.InValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_outvalid", 32'(outb.OutValid), 32'd0);
        chk("t5_inready", 32'(inb.InReady), 32'd1);
        chk("t5_op", 32'(outb.OutOp), 32'(CLR));
        chk("t5_ra", 32'(outb.OutRa), 32'd0);
        chk("t5_ill", 32'(ill_seen), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        outb.OutReady = 1'b1;
        inb.InValid   = 1'b1;
        inb.InstIn    = 9'b101_011_100;
        @(negedge clk);
        chk_out("t5_post", SUB, 3'd3, 3'd4);
        inb.InValid = 1'b0;
        @(negedge clk);
        chk("t5_noleak", 32'(outb.OutValid), 32'd0);

`ifdef DECODE_STALL_CNT_EN
        // 6: stall counter counts and saturates
        chk("t6_zero", 32'(stall_cnt), 32'd0);
        outb.OutReady = 1'b0;
        inb.InValid   = 1'b1;
        inb.InstIn    = 9'b100_001_001;
        @(negedge clk);
        inb.InValid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t6_five", 32'(stall_cnt), 32'd5);
        repeat (70000) @(negedge clk);
        chk("t6_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
